// File: rtl/tmds_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tmds_pkg : shared symbols, types and helpers for the TMDS channel encoder
// Rev 1.0
// ---------------------------------------------------------------------------
package tmds_pkg;

  typedef logic [9:0]        tmds_sym_t;
  typedef logic signed [4:0] disp_t;

  localparam tmds_sym_t CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_11 = 10'b1010101011;

  localparam tmds_sym_t GB_CH02 = 10'b1011001100;
  localparam tmds_sym_t GB_CH1  = 10'b0100110011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_qm_encode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tmds_qm_encode : stage-1 transition minimisation (q_m) with its register
// Rev 1.0
// ---------------------------------------------------------------------------
module tmds_qm_encode
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       data_en,
  input  logic [7:0] data,
  input  logic [1:0] ctl,
  output logic [8:0] qm,
  output logic       qm_data_en,
  output logic [1:0] qm_ctl
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] qm_next;

  always_comb begin
    n1       = popcount8(data);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
    qm_next    = '0;
    qm_next[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ data[i]) : (qm_next[i-1] ^ data[i]);
    end
    qm_next[8] = ~use_xnor;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      qm         <= '0;
      qm_data_en <= 1'b0;
      qm_ctl     <= 2'b00;
    end else begin
      qm         <= qm_next;
      qm_data_en <= data_en;
      qm_ctl     <= ctl;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tmds_channel_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tmds_channel_encoder : DVI TMDS 8b/10b channel encoder, 2-cycle latency
// (4 cycles with video guard band when TMDS_GUARD_BAND_EN is defined). Rev 1.0
// ---------------------------------------------------------------------------
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_data_en,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctl,
  output logic [9:0] o_tmds,
  output logic [4:0] o_disparity
);

  localparam tmds_sym_t GB_CODE = (CHANNEL == 1) ? GB_CH1 : GB_CH02;

  logic       enc_data_en;
  logic [7:0] enc_data;
  logic [1:0] enc_ctl;
  logic       guard;

  logic [8:0] qm;
  logic       qm_data_en;
  logic [1:0] qm_ctl;

`ifdef TMDS_GUARD_BAND_EN
  // Two-deep look-ahead so the output stage can see an upcoming video period.
  logic       dly1_data_en, dly2_data_en;
  logic [7:0] dly1_data,    dly2_data;
  logic [1:0] dly1_ctl,     dly2_ctl;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dly1_data_en <= 1'b0;
      dly2_data_en <= 1'b0;
      dly1_data    <= '0;
      dly2_data    <= '0;
      dly1_ctl     <= 2'b00;
      dly2_ctl     <= 2'b00;
    end else begin
      dly1_data_en <= i_data_en;
      dly1_data    <= i_data;
      dly1_ctl     <= i_ctl;
      dly2_data_en <= dly1_data_en;
      dly2_data    <= dly1_data;
      dly2_ctl     <= dly1_ctl;
    end
  end

  assign enc_data_en = dly2_data_en;
  assign enc_data    = dly2_data;
  assign enc_ctl     = dly2_ctl;
`else
  assign enc_data_en = i_data_en;
  assign enc_data    = i_data;
  assign enc_ctl     = i_ctl;
`endif

  tmds_qm_encode u_qm_encode (
    .clk        (clk),
    .rstn       (rstn),
    .data_en    (enc_data_en),
    .data       (enc_data),
    .ctl        (enc_ctl),
    .qm         (qm),
    .qm_data_en (qm_data_en),
    .qm_ctl     (qm_ctl)
  );

`ifdef TMDS_GUARD_BAND_EN
  assign guard = ~qm_data_en & (dly2_data_en | dly1_data_en);
`else
  assign guard = 1'b0;
`endif

  disp_t     cnt;
  disp_t     n1, n0, diff, cnt_next;
  logic      cnt_zero, cnt_pos, cnt_neg, diff_pos, diff_neg;
  tmds_sym_t ctrl_code, sym_next;

  always_comb begin
    n1       = disp_t'({1'b0, popcount8(qm[7:0])});
    n0       = 5'sd8 - n1;
    diff     = n1 - n0;
    cnt_zero = (cnt == '0);
    cnt_pos  = !cnt[4] && !cnt_zero;
    cnt_neg  = cnt[4];
    diff_pos = !diff[4] && (diff != '0);
    diff_neg = diff[4];

    case (qm_ctl)
      2'b00:   ctrl_code = CTRL_00;
      2'b01:   ctrl_code = CTRL_01;
      2'b10:   ctrl_code = CTRL_10;
      default: ctrl_code = CTRL_11;
    endcase

    sym_next = ctrl_code;
    cnt_next = '0;
    if (guard) begin
      sym_next = GB_CODE;
    end else if (qm_data_en) begin
      if (cnt_zero || (diff == '0)) begin
        sym_next = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_next = qm[8] ? (cnt + diff) : (cnt - diff);
      end else if ((cnt_pos && diff_pos) || (cnt_neg && diff_neg)) begin
        sym_next = {1'b1, qm[8], ~qm[7:0]};
        cnt_next = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        sym_next = {1'b0, qm[8], qm[7:0]};
        cnt_next = cnt - (qm[8] ? 5'sd0 : 5'sd2) + diff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_tmds <= CTRL_00;
      cnt    <= '0;
    end else begin
      o_tmds <= sym_next;
      cnt    <= cnt_next;
    end
  end

  assign o_disparity = cnt;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tmds_channel_encoder : randomized + directed bench with a behavioural
// TMDS model (parity-form q_m, integer disparity). Rev 1.0
// ---------------------------------------------------------------------------
module tb_tmds_channel_encoder;

`ifdef TMDS_GUARD_BAND_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int CH = 1;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_data_en;
  logic [7:0] i_data;
  logic [1:0] i_ctl;
  logic [9:0] o_tmds;
  logic [4:0] o_disparity;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
  } samp_t;

  samp_t      hist[$];
  int         mcnt = 0;
  logic [9:0] exp_sym;
  logic       exp_data;
  logic [7:0] exp_byte;
  logic [4:0] exp_disp;
  logic [9:0] last_obs;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  tmds_channel_encoder #(.CHANNEL(CH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_data_en   (i_data_en),
    .i_data      (i_data),
    .i_ctl       (i_ctl),
    .o_tmds      (o_tmds),
    .o_disparity (o_disparity)
  );

  // q_m[i] is the parity of d[i:0]; the XNOR chain additionally flips odd bits.
  function automatic logic [8:0] min_trans(input logic [7:0] d);
    int         ones;
    logic       xn;
    logic [8:0] q;
    logic [7:0] m;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q  = '0;
    for (int i = 0; i < 8; i++) begin
      m    = 8'((2 << i) - 1);
      q[i] = (^(d & m)) ^ (xn && (i % 2 == 1));
    end
    q[8] = !xn;
    return q;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] b, d;
    b    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] ctrl_of(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  task automatic model_data(input logic [7:0] d);
    logic [8:0] q;
    int n1, n0;
    q  = min_trans(d);
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(q[i]);
    n0 = 8 - n1;
    if (mcnt == 0 || n1 == n0) begin
      exp_sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      mcnt   += q[8] ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
      exp_sym = {1'b1, q[8], ~q[7:0]};
      mcnt   += 2 * int'(q[8]) + (n0 - n1);
    end else begin
      exp_sym = {1'b0, q[8], q[7:0]};
      mcnt   += -2 * int'(!q[8]) + (n1 - n0);
    end
  endtask

  task automatic cycle(input logic de, input logic [7:0] d, input logic [1:0] c, input logic rn);
    samp_t s, cur;
    i_data_en = de;
    i_data    = d;
    i_ctl     = c;
    rstn      = rn;
    @(posedge clk);
    if (!rn) begin
      hist.delete();
      for (int i = 0; i < LAT - 1; i++) hist.push_back('0);
      exp_sym  = 10'b1101010100;
      mcnt     = 0;
      exp_data = 1'b0;
    end else begin
      s = '{de: de, d: d, c: c};
      hist.push_back(s);
      cur      = hist.pop_front();
      exp_data = cur.de;
      exp_byte = cur.d;
      if (cur.de) begin
        model_data(cur.d);
      end else begin
        mcnt    = 0;
        exp_sym = ctrl_of(cur.c);
`ifdef TMDS_GUARD_BAND_EN
        if (hist[0].de || hist[1].de) exp_sym = (CH == 1) ? 10'b0100110011 : 10'b1011001100;
`endif
      end
    end
    #1;
    last_obs = o_tmds;
    exp_disp = mcnt[4:0];
    vectors++;
    assert (o_tmds === exp_sym) else begin
      miscompares++;
      $error("FAIL tmds obs=%b exp=%b", o_tmds, exp_sym);
    end
    vectors++;
    assert (o_disparity === exp_disp) else begin
      miscompares++;
      $error("FAIL disparity obs=%0d exp=%0d", $signed(o_disparity), $signed(exp_disp));
    end
    if (exp_data) begin
      vectors++;
      assert (tmds_decode(o_tmds) === exp_byte) else begin
        miscompares++;
        $error("FAIL decode obs=%h exp=%h", tmds_decode(o_tmds), exp_byte);
      end
    end
    vectors++;
    assert ($signed(o_disparity) >= -10 && $signed(o_disparity) <= 10) else begin
      miscompares++;
      $error("FAIL disp_bound obs=%0d exp=-10..10", $signed(o_disparity));
    end
  endtask

  logic [9:0] zs[3] = '{10'h100, 10'h3FF, 10'h100};
  logic [4:0] zd[3] = '{5'b11000, 5'b00010, 5'b11010};
  logic [9:0] obs[16];
  int         gb_count;

  initial begin
    i_data_en = 1'b0;
    i_data    = 8'h00;
    i_ctl     = 2'b11;
    rstn      = 1'b0;

    // Reset with ctl=11 held three cycles
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 2'b11, 1'b0);
      vectors++;
      assert (o_tmds === 10'h354 && o_disparity === 5'd0) else begin
        miscompares++;
        $error("FAIL reset_hold obs=%h/%0d exp=354/0", o_tmds, o_disparity);
      end
    end

    for (int i = 0; i < LAT; i++) cycle(1'b0, 8'h00, 2'b11, 1'b1);
    vectors++;
    assert (o_tmds === 10'b1010101011) else begin
      miscompares++;
      $error("FAIL ctl11 obs=%b exp=1010101011", o_tmds);
    end

    // Three zero pixels from cnt=0
    for (int i = 0; i < LAT + 2; i++) begin
      int k;
      cycle(i < 3, 8'h00, 2'b00, 1'b1);
      k = i - (LAT - 1);
      if (k >= 0 && k < 3) begin
        vectors++;
        assert (o_tmds === zs[k] && o_disparity === zd[k]) else begin
          miscompares++;
          $error("FAIL zero_run[%0d] obs=%h/%0d exp=%h/%0d", k, o_tmds,
                 $signed(o_disparity), zs[k], $signed(zd[k]));
        end
      end
    end

    // Full byte sweep with random enable and control
    for (int v = 0; v < 256; v++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'(v), 2'($urandom_range(0, 3)), 1'b1);
    end

    // Video -> one blanking cycle -> video
    for (int r = 0; r < 4; r++) begin
      cycle(1'b1, 8'($urandom), 2'($urandom_range(0, 3)), 1'b1);
      cycle(1'b1, 8'($urandom), 2'($urandom_range(0, 3)), 1'b1);
      cycle(1'b0, 8'($urandom), 2'($urandom_range(0, 3)), 1'b1);
      cycle(1'b1, 8'($urandom), 2'($urandom_range(0, 3)), 1'b1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 2'b01, 1'b1);

    // Mid-line reset with nonzero running disparity
    for (int i = 0; i < LAT + 2; i++) cycle(1'b1, 8'h00, 2'b00, 1'b1);
    cycle(1'b1, 8'h00, 2'b00, 1'b0);
    vectors++;
    assert (o_tmds === 10'h354 && o_disparity === 5'd0) else begin
      miscompares++;
      $error("FAIL midline_reset obs=%h/%0d exp=354/0", o_tmds, o_disparity);
    end
    for (int i = 0; i < LAT; i++) cycle(1'b1, 8'h00, 2'b00, 1'b1);
    vectors++;
    assert (o_tmds === 10'h100 && o_disparity === 5'b11000) else begin
      miscompares++;
      $error("FAIL post_reset_first obs=%h/%0d exp=100/-8", o_tmds, $signed(o_disparity));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 2'b00, 1'b1);

`ifdef TMDS_GUARD_BAND_EN
    // Long blanking then video: two guard-band slots, latency 4
    for (int i = 0; i < 10; i++) begin
      cycle(i == 4 || i == 5, 8'h00, 2'b00, 1'b1);
      obs[i] = last_obs;
    end
    vectors++;
    assert (obs[4] === 10'b1101010100 && obs[5] === 10'b0100110011 &&
            obs[6] === 10'b0100110011 && obs[7] === 10'h100) else begin
      miscompares++;
      $error("FAIL gb_long obs=%h %h %h %h exp=354 133 133 100", obs[4], obs[5], obs[6], obs[7]);
    end
    // One-cycle gap: a single guard-band slot
    for (int i = 0; i < 7; i++) begin
      cycle(i == 0 || i == 2, 8'h00, 2'b00, 1'b1);
      obs[i] = last_obs;
    end
    gb_count = 0;
    for (int i = 3; i < 6; i++) if (obs[i] === 10'b0100110011) gb_count++;
    vectors++;
    assert (gb_count == 1 && obs[4] === 10'b0100110011) else begin
      miscompares++;
      $error("FAIL gb_short obs=%0d slots exp=1 slot", gb_count);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- One TMDS 8b/10b channel encoder (DVI 1.0 algorithm); sits directly downstream of the timing controller.
- Consumes registered data enable, sync/control bits and 8-bit pixel component.
- Emits a 10-bit symbol per pixel clock to the serializer.
- Three instances per link: CH0 carries {vsync,hsync} as control; CH1/CH2 carry CTL bits.

Parameters:
- CHANNEL, 0, channel index 0..2; selects the guard-band code only.

Ports:
- clk  in  1  pixel clock
- rstn  in  1  synchronous, active-low reset
- i_data_en  in  1  1 = video period, 0 = blanking/control
- i_data  in  8  pixel component, valid when i_data_en=1
- i_ctl  in  2  control bits {c1,c0}, used when i_data_en=0
- o_tmds  out  10  encoded symbol; bit 0 is transmitted first
- o_disparity  out  5  signed running disparity after the current symbol (debug)

Behaviour:
- Clock and reset: single clock clk; reset rstn, synchronous, active-low.
- Reset values:
  - o_tmds = 10'b1101010100 (control code for ctl=00).
  - o_disparity = 0; internal cnt = 0; all pipeline registers cleared, with data_en = 0.
  - Reset asserted mid-frame takes effect on the next edge; no partial symbol is emitted.
- Latency: 2 cycles from input to o_tmds. Fixed; throughput is 1 symbol per clock; no stall.
- Stage 1 (registered):
  - n1 = popcount(i_data).
  - If n1>4 or (n1==4 and i_data[0]==0): XNOR chain, q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - q_m[0]=i_data[0]; q_m[i] = q_m[i-1] op i_data[i].
  - data_en and ctl are registered alongside q_m.
- Stage 2 (registered), when data_en=1:
  - N1/N0 = count of ones/zeros in q_m[7:0].
  - Case A, cnt==0 or N1==N0:
    - o_tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - Case B, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - o_tmds = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0-N1).
  - Case C, otherwise:
    - o_tmds = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (N1-N0).
- Stage 2, when data_en=0:
  - o_tmds = control code: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - cnt forced to 0.
- Width rules: cnt is 5-bit two's complement; it stays within −10..+10 by construction, so there is no wrap. Counts are computed at 5 bits signed before the add.
- Transitions:
  - Blanking→video: the first data symbol starts from cnt=0.
  - Video→blanking: cnt is discarded.
  - Single-cycle data_en pulses are legal and encode normally.

Optional Feature:
- Macro TMDS_GUARD_BAND_EN.
- Defined:
  - Inputs pass through 2 extra registers; total latency is 4.
  - When data_en at output stage is 0 and either of the next two queued data_en samples is 1, o_tmds = video guard band instead of the control code: CHANNEL 0/2 → 1011001100, CHANNEL 1 → 0100110011.
  - cnt stays 0 during guard band.
  - If data_en rises with fewer than 2 blanking cycles ahead of it, guard band replaces only the available blanking slots.
- Undefined: latency 2, no guard band, as above.

Decomposition:
- Package tmds_pkg holds:
  - control-code constants CTRL_00..CTRL_11;
  - guard-band constants GB_CH02, GB_CH1;
  - typedef tmds_sym_t (10-bit) and disp_t (5-bit signed);
  - function popcount8.
- One natural sub-module, tmds_qm_encode: stage-1 transition-minimization plus its register.

Test Plan:
- Reset held 3 cycles with i_ctl=11 → o_tmds=0x354 and o_disparity=0 throughout. After release, i_data_en=0, i_ctl=11 → o_tmds=10'b1010101011 two cycles later.
- i_data_en=1, i_data=0x00 for 3 consecutive cycles from cnt=0 → o_tmds sequence 0x100, 0x3FF, 0x100; o_disparity −8, +2, −6.
- Sweep all 256 i_data values with random data_en and ctl → o_tmds matches a reference model each cycle, and decoding recovers i_data. |cnt| ≤ 10 always.
- Video→blanking→video with data_en low for 1 cycle → control symbol emitted; first new data symbol is encoded with cnt=0.
- rstn asserted mid-line with cnt≠0 → next cycle o_tmds=0x354, o_disparity=0. First symbol after release matches the cnt=0 encoding.
- TMDS_GUARD_BAND_EN, CHANNEL=1, blanking then data_en rising → exactly 2 symbols of 0100110011 immediately before the first data symbol; latency 4 measured. With a 1-cycle blanking gap → 1 guard-band symbol.
